// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks: Montgomery multiplier state encoding
// and the iteration count for an R = 2^(WIDTH+2) reduction.
package rsa_pkg;

    typedef enum logic [1:0] {
        MMM_IDLE,
        MMM_RUN,
        MMM_SUB,
        MMM_DONE
    } mmm_state_t;

    function automatic int steps(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/mmm_serial_unit_if.sv
// Request/response bundle between the exponentiation sequencer (master) and the
// bit-serial Montgomery multiplier (slave).
interface mmm_serial_unit_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             start;
    logic [WIDTH+1:0] a_i;
    logic [WIDTH+1:0] b_i;
    logic [WIDTH+1:0] m_i;
    logic             busy;
    logic             done;
    logic [WIDTH+1:0] result;

    modport master (
        output ena, start, a_i, b_i, m_i,
        input  busy, done, result
    );

    modport slave (
        input  ena, start, a_i, b_i, m_i,
        output busy, done, result
    );
endinterface

// File: rtl/mmm_serial_unit_step_adder.sv
// One Montgomery iteration: quotient bit, three-input add and halving of the
// accumulator. Purely combinational.
module mmm_step_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+3:0] i_p,
    input  logic             i_a_bit,
    input  logic [WIDTH+1:0] i_b,
    input  logic [WIDTH+1:0] i_m,
    output logic [WIDTH+3:0] o_p
);
    logic             w_q;
    logic [WIDTH+4:0] w_sum;

    // q makes the sum even, so the shift below drops only a zero bit.
    always_comb begin
        w_q   = i_p[0] ^ (i_a_bit & i_b[0]);
        w_sum = {1'b0, i_p}
              + (i_a_bit ? {3'b000, i_b} : '0)
              + (w_q     ? {3'b000, i_m} : '0);
        o_p   = (WIDTH+4)'(w_sum >> 1);
    end
endmodule

// File: rtl/mmm_serial_unit.sv
// Bit-serial Montgomery multiplier: result = A*B*2^-(WIDTH+2) mod M, one step per enabled cycle.
// Define MMM_FINAL_SUB_EN to add a final conditional subtraction (result fully reduced, < M).
module mmm_serial_unit
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstb,
    mmm_serial_unit_if.slave     bus
);
    localparam int              OW   = WIDTH + 2;
    localparam int              PW   = WIDTH + 4;
    localparam int              CW   = $clog2(steps(WIDTH));
    localparam logic [CW-1:0]   LAST = CW'(steps(WIDTH) - 1);

    mmm_state_t     r_state;
    mmm_state_t     w_next_state;
    logic [OW-1:0]  r_a;
    logic [OW-1:0]  r_b;
    logic [OW-1:0]  r_m;
    logic [PW-1:0]  r_p;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic [OW-1:0]  r_result;
    logic [PW-1:0]  w_p_step;
    logic           w_last;

    mmm_step_adder #(.WIDTH(WIDTH)) u_step (
        .i_p     (r_p),
        .i_a_bit (r_a[0]),
        .i_b     (r_b),
        .i_m     (r_m),
        .o_p     (w_p_step)
    );

`ifdef MMM_FINAL_SUB_EN
    logic [PW-1:0]  w_sub_p;
    assign w_sub_p = (r_p >= {2'b00, r_m}) ? (r_p - {2'b00, r_m}) : r_p;
`endif

    assign w_last = (r_state == MMM_RUN) && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state <= MMM_IDLE;
        end else if (bus.ena) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MMM_IDLE: if (bus.start) w_next_state = MMM_RUN;
`ifdef MMM_FINAL_SUB_EN
            MMM_RUN:  if (w_last) w_next_state = MMM_SUB;
`else
            MMM_RUN:  if (w_last) w_next_state = MMM_DONE;
`endif
            MMM_SUB:  w_next_state = MMM_DONE;
            MMM_DONE: w_next_state = MMM_IDLE;
            default:  w_next_state = MMM_IDLE;
        endcase
    end

    // Outputs are registered so they freeze with ena; done is set on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (bus.ena) begin
            r_done <= 1'b0;
            case (r_state)
                MMM_IDLE: begin
                    if (bus.start) begin
                        r_a    <= bus.a_i;
                        r_b    <= bus.b_i;
                        r_m    <= bus.m_i;
                        r_p    <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                MMM_RUN: begin
                    r_p <= w_p_step;
                    r_a <= r_a >> 1;
                    if (w_last) begin
`ifndef MMM_FINAL_SUB_EN
                        r_result <= OW'(w_p_step);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                MMM_SUB: begin
`ifdef MMM_FINAL_SUB_EN
                    r_result <= OW'(w_sub_p);
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_mmm_serial_unit.sv
// Bench for mmm_serial_unit (WIDTH=8): table vectors, multi-cycle corner sequences and
// random operands against a modular-arithmetic reference. Honors MMM_FINAL_SUB_EN.
module tb_mmm_serial_unit;
    localparam int W = 8;
`ifdef MMM_FINAL_SUB_EN
    localparam int LAT = 11;
    localparam bit SUB = 1'b1;
`else
    localparam int LAT = 10;
    localparam bit SUB = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstb = 1'b0;

    mmm_serial_unit_if #(.WIDTH(W)) bus ();

    mmm_serial_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int a;
        int b;
        int expm;
    } vec_t;

    vec_t tbl[8];

    // a*b*R^-1 mod m, with R^-1 applied as W+2 modular halvings.
    function automatic int ref_mmm(input int a, input int b, input int m);
        int v;
        v = (a * b) % m;
        for (int i = 0; i < W + 2; i++) begin
            if (v % 2 == 1) v = v + m;
            v = v / 2;
        end
        return v;
    endfunction

    function automatic int bnd(input int m);
        return SUB ? m : 2 * m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // mode 0: plain run; 1: extra start pulses at cycles 3 and 7; 2: ena low for cycles 4..6.
    task automatic run_op(input int a, input int b, input int m, input int mode,
                          output int res, output int lat, output int ndone, output int busy_ok);
        bus.a_i   = 10'(a);
        bus.b_i   = 10'(b);
        bus.m_i   = 10'(m);
        bus.start = 1'b1;
        bus.ena   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a_i   = 10'($urandom);
        bus.b_i   = 10'($urandom);
        bus.m_i   = 10'($urandom);
        res = 0; lat = -1; ndone = 0; busy_ok = 0;
        for (int c = 1; c <= 40; c++) begin
            bus.start = (mode == 1) && (c == 3 || c == 7);
            bus.ena   = !((mode == 2) && c >= 4 && c <= 6);
            @(posedge clk); #1;
            if (c == 1) busy_ok = int'(bus.busy);
            if (bus.done === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    res = int'(bus.result);
                    if (bus.busy !== 1'b0) busy_ok = 0;
                end
            end
            if (lat >= 0 && c >= lat + 2) break;
        end
        bus.start = 1'b0;
        bus.ena   = 1'b1;
    endtask

    initial begin
        int res, lat, nd, bo, r0, m, a, b, cnt;

        tbl[0] = '{0,   'h1AB, 0};
        tbl[1] = '{180, 5,     5};
        tbl[2] = '{180, 180,   180};
        tbl[3] = '{1,   1,     34};
        tbl[4] = '{2,   3,     204};
        tbl[5] = '{210, 210,   34};
        tbl[6] = '{421, 1,     177};
        tbl[7] = '{421, 421,   34};

        bus.ena = 1'b1; bus.start = 1'b0;
        bus.a_i = '0; bus.b_i = '0; bus.m_i = '0;
        rstb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   bus.busy,   0);
        check("rst_done",   bus.done,   0);
        check("rst_result", bus.result, 0);
        rstb = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, 211, 0, res, lat, nd, bo);
            check("tbl_mod",   res % 211, tbl[i].expm);
            check("tbl_range", res < bnd(211), 1);
            check("tbl_lat",   lat, LAT);
            check("tbl_ndone", nd, 1);
            check("tbl_busy",  bo, 1);
            if (i == 0) check("zero_exact", res, 0);
        end

        run_op(45, 99, 211, 1, res, lat, nd, bo);
        check("restart_mod",   res % 211, ref_mmm(45, 99, 211));
        check("restart_lat",   lat, LAT);
        check("restart_ndone", nd, 1);

        run_op(123, 77, 211, 0, r0, lat, nd, bo);
        run_op(123, 77, 211, 2, res, lat, nd, bo);
        check("stall_ref",   r0 % 211, ref_mmm(123, 77, 211));
        check("stall_same",  res, r0);
        check("stall_lat",   lat, LAT + 3);
        check("stall_ndone", nd, 1);

        // done held while ena is low after completion
        bus.a_i = 10'd7; bus.b_i = 10'd9; bus.m_i = 10'd211; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("hold_seen", bus.done, 1);
        bus.ena = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("hold_done", bus.done, 1);
        check("hold_res",  int'(bus.result) % 211, ref_mmm(7, 9, 211));
        bus.ena = 1'b1;
        @(posedge clk); #1;
        check("hold_clear", bus.done, 0);

        // reset during step 5 aborts without a done pulse
        bus.a_i = 10'd180; bus.b_i = 10'd180; bus.m_i = 10'd211; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rstb = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b1;
        check("abort_busy",   bus.busy,   0);
        check("abort_done",   bus.done,   0);
        check("abort_result", bus.result, 0);
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) nd++;
        end
        check("abort_nodone", nd, 0);
        run_op(2, 3, 211, 0, res, lat, nd, bo);
        check("after_abort_mod", res % 211, 204);
        check("after_abort_lat", lat, LAT);

        for (int k = 0; k < 1000; k++) begin
            m = 2 * $urandom_range(1, 127) + 1;
            a = $urandom_range(0, 2 * m - 1);
            b = $urandom_range(0, 2 * m - 1);
            run_op(a, b, m, 0, res, lat, nd, bo);
            check("rand_mod",   res % m, ref_mmm(a, b, m));
            check("rand_range", res < bnd(m), 1);
            check("rand_lat",   lat, LAT);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
